// File: rtl/rop3_result_packer.sv
// ROP3 result packer: gathers PACK results into one wide word and queues packed words
// in a show-ahead FIFO toward the frame-buffer writer; overflowing words are dropped and counted.
`timescale 1ns/1ps
module rop3_result_packer #(
    parameter int unsigned N     = 8,
    parameter int unsigned PACK  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      srst_n,
    input  logic [N-1:0]              in_data,
    input  logic                      in_valid,
    input  logic                      flush,
    output logic [PACK*N-1:0]         out_data,
    output logic [$clog2(PACK+1)-1:0] out_count,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic [7:0]                drop_cnt
);
    localparam int unsigned PW = $clog2(PACK);
    localparam int unsigned CW = $clog2(PACK+1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH+1);
    localparam int unsigned W  = PACK*N;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  buf_q, buf_d, word;
    logic [CW-1:0] push_count;
    logic          complete, push;

    logic [W-1:0]  mem_data_q [DEPTH];
    logic [CW-1:0] mem_cnt_q  [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [OW-1:0] occ_q, occ_d;
    logic          full, pop, wr_en, drop;
    logic          overflow_q;
    logic [7:0]    drop_cnt_q;

    // Word as it would look with the current result merged into its lane.
    always_comb begin
        word = buf_q;
        for (int i = 0; i < PACK; i++) begin
            if (in_valid && ptr_q == PW'(i)) begin
                word[i*N +: N] = in_data;
            end
        end
    end

    assign complete   = in_valid && (ptr_q == PW'(PACK-1));
    assign push       = complete || (flush && (ptr_q != '0 || in_valid));
    assign push_count = complete ? CW'(PACK) : CW'(ptr_q) + CW'(in_valid);

    always_comb begin
        ptr_d = ptr_q;
        buf_d = buf_q;
        if (push) begin
            ptr_d = '0;
            buf_d = '0;
        end else if (in_valid) begin
            ptr_d = ptr_q + PW'(1);
            buf_d = word;
        end
    end

    assign out_valid = (occ_q != '0);
    assign full      = (occ_q == OW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // At full occupancy a simultaneous pop frees the head slot, which wr_q points at.
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_comb begin
        occ_d = occ_q;
        if (wr_en && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !wr_en) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            ptr_q      <= '0;
            buf_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_cnt_q[i]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            buf_q <= buf_d;
            occ_q <= occ_d;
            if (wr_en) begin
                mem_data_q[wr_q] <= word;
                mem_cnt_q[wr_q]  <= push_count;
                wr_q             <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    assign out_data  = out_valid ? mem_data_q[rd_q] : '0;
    assign out_count = out_valid ? mem_cnt_q[rd_q] : '0;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rop3_result_packer.sv
// Directed bench for rop3_result_packer (N=8, PACK=4, DEPTH=4); inputs change and
// outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_rop3_result_packer;
    logic        clk = 1'b0;
    logic        srst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rop3_result_packer #(.N(8), .PACK(4), .DEPTH(4)) dut (
        .clk       (clk),
        .srst_n    (srst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_word(input int k);
        for (int j = 0; j < 4; j++) send(8'(4*k + j));
    endtask

    function automatic logic [31:0] word_of(input int k);
        return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endfunction

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_count"}, 32'(out_count), 32'd0);
    endtask

    initial begin
        srst_n    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk_idle("rst");
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);

        // One queued word plus a half-built one, then asynchronous reset.
        send_word(0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        send(8'h55);
        send(8'h66);
        #2 srst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("post_rst_data", out_data, 32'h44332211);
        chk("post_rst_count", 32'(out_count), 32'd4);
        pop_one();
        chk("post_rst_drain", 32'(out_valid), 32'd0);

        // Latency with consumer always ready.
        out_ready = 1'b1;
        send(8'hA1);
        chk("lat_a1", 32'(out_valid), 32'd0);
        send(8'hA2);
        send(8'hA3);
        chk("lat_a3", 32'(out_valid), 32'd0);
        send(8'hA4);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", out_data, 32'hA4A3A2A1);
        chk("lat_count", 32'(out_count), 32'd4);
        @(negedge clk);
        chk("lat_gone", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Partial flush, empty flush, flush with a result, flush on completion.
        send(8'h01);
        send(8'h02);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl2_data", out_data, 32'h00000201);
        chk("fl2_count", 32'(out_count), 32'd2);
        pop_one();
        chk("fl2_drain", 32'(out_valid), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_empty", 32'(out_valid), 32'd0);
        send(8'h01);
        send(8'h02);
        flush = 1'b1;
        send(8'h03);
        flush = 1'b0;
        chk("fl3_data", out_data, 32'h00030201);
        chk("fl3_count", 32'(out_count), 32'd3);
        pop_one();
        chk("fl3_drain", 32'(out_valid), 32'd0);
        send(8'h05); send(8'h06); send(8'h07);
        flush = 1'b1;
        send(8'h08);
        flush = 1'b0;
        chk("fl4_data", out_data, 32'h08070605);
        chk("fl4_count", 32'(out_count), 32'd4);
        pop_one();
        chk("fl4_single", 32'(out_valid), 32'd0);

        // Overflow and saturation with consumer stalled.
        for (int k = 0; k < 4; k++) send_word(k);
        chk("ovf_pre", 32'(overflow), 32'd0);
        chk("ovf_pre_cnt", 32'(drop_cnt), 32'd0);
        send_word(4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt1", 32'(drop_cnt), 32'd1);
        chk("ovf_head", out_data, word_of(0));
        for (int k = 0; k < 300; k++) send_word(5 + k);
        chk("ovf_sat", 32'(drop_cnt), 32'd255);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_drain%0d", k), out_data, word_of(k));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("ovf_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop.
        srst_n = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        chk("full_rst_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) send_word(k);
        send(8'd16); send(8'd17); send(8'd18);
        out_ready = 1'b1;
        send(8'd19);
        out_ready = 1'b0;
        chk("full_ovf", 32'(overflow), 32'd0);
        chk("full_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("full_drain%0d", k), out_data, word_of(k));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("full_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
